// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Latency: n/a (declarations only); backpressure: n/a.
package dmem_arb_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of dmem_arbiter; slave = arbiter view, master = requester/memory view.
// Latency: n/a (wiring only); backpressure: req is held until the matching gnt pulse.
interface dmem_arbiter_if #(
  parameter int AW = dmem_arb_pkg::DMEM_AW,
  parameter int DW = dmem_arb_pkg::DMEM_DW
);

  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_din, mem_we
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/dmem_arbiter_arb2_pick.sv
// Combinational two-way picker: prio_ptr names the port that wins a tie.
// Latency: 0 cycles; backpressure: none, losers simply stay pending upstream.
module arb2_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio_ptr,
  output logic       win_valid,
  output logic       win_idx
);

  always_comb begin
    win_valid = |req;
    win_idx   = PORT_CPU;
    if (prio_ptr == PORT_DBG) begin
      win_idx = req[1] ? PORT_DBG : PORT_CPU;
    end else begin
      win_idx = (!req[0] && req[1]) ? PORT_DBG : PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port data memory; DMEM_ARB_RR_EN selects round-robin over fixed priority.
// Latency: gnt 1 cycle after req is sampled, rvalid 1 cycle after gnt; backpressure: one access per 2 cycles, losers wait.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  state_e        state_q, state_d;
  logic          win_idx_q, win_idx_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          prio_ptr;
  logic          win_valid;
  logic          win_idx;
  logic          access;

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PORT_CPU;
    else     ptr_q <= ptr_d;
  end

  // Hand priority to whichever port did not just get the memory.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_ACCESS) ptr_d = ~win_idx_q;
  end

  assign prio_ptr = ptr_q;
`else
  assign prio_ptr = PORT_CPU;
`endif

  arb2_pick u_pick (
    .req       ({bus.req1, bus.req0}),
    .prio_ptr  (prio_ptr),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      win_idx_q <= PORT_CPU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_idx_q <= win_idx_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_idx_d = win_idx_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d   = ST_ACCESS;
          win_idx_d = win_idx;
          we_d      = (win_idx == PORT_DBG) ? bus.we1    : bus.we0;
          addr_d    = (win_idx == PORT_DBG) ? bus.addr1  : bus.addr0;
          wdata_d   = (win_idx == PORT_DBG) ? bus.wdata1 : bus.wdata0;
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
        if (!we_q) begin
          rdata_d   = bus.mem_dout;
          rvalid0_d = (win_idx_q == PORT_CPU);
          rvalid1_d = (win_idx_q == PORT_DBG);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset kills the access combinationally so a write in flight never reaches the memory.
  always_comb begin
    access       = (state_q == ST_ACCESS) && !rst;
    bus.gnt0     = access && (win_idx_q == PORT_CPU);
    bus.gnt1     = access && (win_idx_q == PORT_DBG);
    bus.mem_we   = access && we_q;
    bus.mem_addr = addr_q;
    bus.mem_din  = wdata_q;
    bus.rdata    = rdata_q;
    bus.rvalid0  = rvalid0_q;
    bus.rvalid1  = rvalid1_q;
  end

endmodule
